multdiv_iter: RTL and testbench

- Iterative signed 32-bit multiplier and divider. It sits directly upstream of the ALU.
- Multiply: radix-2 Booth. Each iteration drives the ALU with the partial-product upper half and the multiplicand, using opcode add (00000) or sub (00001), and consumes alu_result/alu_overflow on the same cycle.
- Divide: restoring division on operand magnitudes with an internal 33-bit subtractor.
- Results are delivered with a one-cycle ready pulse.

---
 rtl/multdiv_iter.sv | 142 ++++++++++++++
 tb/tb_multdiv_iter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/multdiv_iter.sv
// Iterative signed 32-bit Booth multiplier / restoring divider feeding an external ALU.
// Optional MULTDIV_EARLY_DIV0_EN: divide-by-zero completes without iterating.
module multdiv_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic [WIDTH-1:0] alu_operandA,
  output logic [WIDTH-1:0] alu_operandB,
  output logic [4:0]       alu_opcode,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_overflow
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    counter;
  logic             is_mult;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             q;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] rem;
  logic             neg;
  logic             div0;
  logic             dovf;

  logic             start;
  logic             mult_run;
  logic [1:0]       booth;
  logic             sgn;
  logic [WIDTH:0]   rsh;
  logic             ge;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH-1:0] min_int;

  assign start    = ctrl_MULT | ctrl_DIV;
  assign mult_run = (state == RUN) && is_mult;
  assign booth    = {lo[0], q};
  assign min_int  = {1'b1, {(WIDTH-1){1'b0}}};

  assign alu_opcode   = (mult_run && booth == 2'b10) ? 5'b00001 : 5'b00000;
  assign alu_operandA = mult_run ? hi : '0;
  assign alu_operandB = (mult_run && (booth[1] ^ booth[0])) ? opb : '0;

  // True sign of the 33-bit partial sum, recovered from the ALU overflow flag
  assign sgn = alu_result[WIDTH-1] ^ alu_overflow;

  assign rsh = {rem, lo[WIDTH-1]};
  assign ge  = rsh >= {1'b0, opb};

  assign a_abs = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign b_abs = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      counter        <= '0;
      is_mult        <= 1'b0;
      hi             <= '0;
      lo             <= '0;
      q              <= 1'b0;
      opb            <= '0;
      rem            <= '0;
      neg            <= 1'b0;
      div0           <= 1'b0;
      dovf           <= 1'b0;
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      data_resultRDY <= 1'b0;
      if (start) begin
        data_exception <= 1'b0;
        counter        <= '0;
        state          <= RUN;
        if (ctrl_MULT) begin
          is_mult <= 1'b1;
          hi      <= '0;
          lo      <= data_operandB;
          q       <= 1'b0;
          opb     <= data_operandA;
        end else begin
          is_mult <= 1'b0;
          rem     <= '0;
          lo      <= a_abs;
          opb     <= b_abs;
          neg     <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
          div0    <= (data_operandB == '0);
          dovf    <= (data_operandA == min_int) && (&data_operandB);
`ifdef MULTDIV_EARLY_DIV0_EN
          if (data_operandB == '0) state <= DONE;
`endif
        end
      end else begin
        case (state)
          RUN: begin
            if (is_mult) begin
              hi <= {sgn, alu_result[WIDTH-1:1]};
              lo <= {alu_result[0], lo[WIDTH-1:1]};
              q  <= lo[0];
            end else begin
              rem <= ge ? rsh[WIDTH-1:0] - opb : rsh[WIDTH-1:0];
              lo  <= {lo[WIDTH-2:0], ge};
            end
            counter <= counter + 1'b1;
            if (counter == LAST) state <= DONE;
          end
          DONE: begin
            data_resultRDY <= 1'b1;
            state          <= IDLE;
            if (is_mult) begin
              data_result    <= lo;
              data_exception <= (hi != {WIDTH{lo[WIDTH-1]}});
            end else begin
              data_result    <= div0 ? '0 : (neg ? -lo : lo);
              data_exception <= div0 | dovf;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multdiv_iter.sv
// Scoreboard bench for multdiv_iter with a behavioural add/sub ALU.
// Checks result, exception and RDY timing for directed vectors.
module tb_multdiv_iter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        alu_overflow;

  multdiv_iter dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .alu_operandA   (alu_operandA),
    .alu_operandB   (alu_operandB),
    .alu_opcode     (alu_opcode),
    .alu_result     (alu_result),
    .alu_overflow   (alu_overflow)
  );

  always #5 clock = ~clock;

  always_comb begin
    alu_result   = '0;
    alu_overflow = 1'b0;
    if (alu_opcode == 5'b00001) begin
      alu_result   = alu_operandA - alu_operandB;
      alu_overflow = (alu_operandA[31] != alu_operandB[31]) &&
                     (alu_result[31] != alu_operandA[31]);
    end else begin
      alu_result   = alu_operandA + alu_operandB;
      alu_overflow = (alu_operandA[31] == alu_operandB[31]) &&
                     (alu_result[31] != alu_operandA[31]);
    end
  end

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          at;
    string       name;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;

`ifdef MULTDIV_EARLY_DIV0_EN
  localparam int DIV0_LAT = 1;
`else
  localparam int DIV0_LAT = 33;
`endif

  task automatic check(input string n, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, req);
    end
  endtask

  // Monitor: every RDY pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (!reset && data_resultRDY === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rdy actual=1 required=0 cycle=%0d", cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "_result"}, data_result, e.res);
        check({e.name, "_exc"}, {31'b0, data_exception}, {31'b0, e.exc});
        check({e.name, "_rdy_cycle"}, cyc, e.at);
      end
    end
  end

  task automatic start(input bit m, input bit d, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] res,
                       input bit exc, input int lat, input string name);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
    sb.delete();
    sb.push_back('{res, exc, cyc + lat, name});
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(posedge clock);
      n++;
    end
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL timeout_%s actual=no_rdy required=rdy", sb[0].name);
      sb.delete();
    end
    repeat (3) @(posedge clock);
  endtask

  task automatic run(input bit m, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] res, input bit exc, input int lat,
                     input string name);
    start(m, !m, a, b, res, exc, lat, name);
    drain();
  endtask

  task automatic check_zero(input string p);
    check({p, "_result"}, data_result, 32'h0);
    check({p, "_exc"}, {31'b0, data_exception}, 32'h0);
    check({p, "_rdy"}, {31'b0, data_resultRDY}, 32'h0);
    check({p, "_opcode"}, {27'b0, alu_opcode}, 32'h0);
    check({p, "_alu_a"}, alu_operandA, 32'h0);
    check({p, "_alu_b"}, alu_operandB, 32'h0);
  endtask

  initial begin
    #12;
    check_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    run(1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 0, 33, "mul_7_m3");
    run(1, 32'h7FFFFFFF, 32'd2,        32'hFFFFFFFE, 1, 33, "mul_max_2");
    run(1, 32'h80000000, 32'd1,        32'h80000000, 0, 33, "mul_min_1");
    run(1, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd30,       0, 33, "mul_m5_m6");
    run(1, 32'h00010000, 32'h00010000, 32'h0,        1, 33, "mul_2p32");
    run(0, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 0, 33, "div_m7_2");
    run(0, 32'd100,      32'hFFFFFFF6, 32'hFFFFFFF6, 0, 33, "div_100_m10");
    run(0, 32'd5,        32'd0,        32'h0,        1, DIV0_LAT, "div_5_0");
    run(0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 33, "div_min_m1");
    run(0, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14,       0, 33, "div_m100_m7");
    run(0, 32'h80000000, 32'd2,        32'hC0000000, 0, 33, "div_min_2");
    run(0, 32'd3,        32'd7,        32'd0,        0, 33, "div_3_7");

    start(1, 1, 32'd6, 32'd7, 32'd42, 0, 33, "both_mul_wins");
    drain();

    start(1, 0, 32'd3, 32'd4, 32'd12, 0, 33, "abort_mul");
    repeat (9) @(posedge clock);
    start(0, 1, 32'd20, 32'd5, 32'd4, 0, 33, "abort_div");
    drain();

    start(1, 0, 32'd3, 32'd5, 32'd15, 0, 33, "rst_mul");
    repeat (15) @(posedge clock);
    #3;
    reset = 1'b1;
    sb.delete();
    #1;
    check_zero("midrun_reset");
    @(negedge clock);
    reset = 1'b0;
    run(1, 32'd2, 32'd3, 32'd6, 0, 33, "post_rst_mul");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
